ofdm_sc_timing_sync: RTL

- Streaming Schmidl-Cox timing synchroniser for the real-valued (DCO-OFDM) VLC receive path; parametrised successor of the batch BRAM time-sync block.
- Consumes one sample per accepted beat and keeps running correlation P and energy R with O(1) updates. No frame buffering and no division.
- Reports the sample index of the preamble start, plus P and R at the peak, to the downstream CP-removal / channel-estimation stage.

---
 rtl/ofdm_sc_timing_sync.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/ofdm_sc_timing_sync.sv
// Streaming Schmidl-Cox timing synchroniser for the real-valued VLC receive path.
// Keeps a sliding lag-L correlation P and window energy R with O(1) updates, tests
// P^2 against a fraction of R^2 one cycle later, and tracks the correlation peak.
// Pipeline: accept/update -> threshold test -> peak-search FSM.
module ofdm_sc_timing_sync #(
    parameter int DATA_W    = 8,
    parameter int L         = 32,
    parameter int IDX_W     = 13,
    parameter int THR_NUM   = 3,
    parameter int THR_SHIFT = 2,
    parameter int PEAK_WIN  = 16,
    localparam int PW       = 2*DATA_W + $clog2(L) + 1,
    localparam int RW       = 2*DATA_W + $clog2(L)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    input  logic signed [DATA_W-1:0] s_data,
    input  logic                     rearm,
    output logic                     det_valid,
    output logic [IDX_W-1:0]         det_index,
    output logic signed [PW-1:0]     det_p,
    output logic [RW-1:0]            det_r,
    output logic                     busy,
    output logic                     locked
);

    localparam int PRW = 2*DATA_W;
    localparam int CW  = 2*PW + THR_SHIFT + 2;
    localparam int QW  = $clog2(PEAK_WIN + 1);
    localparam int WW  = $clog2(2*L) + 1;

    typedef enum logic [1:0] {SEARCH, TRACK, DONE} state_t;

    // Update stage: delay line holds x(n-1) .. x(n-2L)
    logic signed [DATA_W-1:0] dline [2*L];
    logic signed [PW-1:0]     p_acc;
    logic [RW-1:0]            r_acc;
    logic [IDX_W-1:0]         n_cnt;
    logic [IDX_W-1:0]         cur_idx;
    logic [WW-1:0]            warm_cnt;
    logic                     s0_valid;
    logic                     s0_warm;

    // Test stage
    logic                     ev_valid;
    logic                     ev_hit;
    logic signed [PW-1:0]     ev_p;
    logic [RW-1:0]            ev_r;
    logic [IDX_W-1:0]         ev_idx;

    // Peak search
    state_t                   state;
    logic signed [PW-1:0]     best_p;
    logic [RW-1:0]            best_r;
    logic [IDX_W-1:0]         best_idx;
    logic [QW-1:0]            quiet;

    logic signed [PRW-1:0]    x_ext, d1_ext, d2_ext;
    logic signed [PRW-1:0]    prod_xd1, prod_d1d2, sq_x, sq_d1;
    logic [CW-1:0]            p_u, r_u, lhs, rhs;
    logic                     p_pos, hit_now;

    // Exact products of the new sample against the lag-L and lag-2L taps
    always_comb begin
        x_ext     = PRW'(s_data);
        d1_ext    = PRW'(dline[L-1]);
        d2_ext    = PRW'(dline[2*L-1]);
        prod_xd1  = x_ext * d1_ext;
        prod_d1d2 = d1_ext * d2_ext;
        sq_x      = x_ext * x_ext;
        sq_d1     = d1_ext * d1_ext;
    end

    // Accept a sample: shift history, slide P and R, advance the index counters
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the delay line is plain flops, so it is cleared here; P and R are
            // only exact if the history they subtract starts at zero.
            for (int i = 0; i < 2*L; i++) dline[i] <= '0;
            p_acc    <= '0;
            r_acc    <= '0;
            n_cnt    <= '0;
            cur_idx  <= '0;
            warm_cnt <= '0;
            s0_valid <= 1'b0;
            s0_warm  <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every read below sees last cycle's value.
            // A sample accepted with rearm still updates P/R but is never tested.
            s0_valid <= s_valid && !rearm;
            if (s_valid) begin
                dline[0] <= s_data;
                for (int i = 1; i < 2*L; i++) dline[i] <= dline[i-1];
                p_acc   <= p_acc + PW'(prod_xd1) - PW'(prod_d1d2);
                r_acc   <= r_acc + RW'($unsigned(sq_x)) - RW'($unsigned(sq_d1));
                cur_idx <= n_cnt;
                n_cnt   <= n_cnt + 1'b1;
                s0_warm <= (warm_cnt >= WW'(2*L - 1));
                if (warm_cnt != WW'(2*L)) warm_cnt <= warm_cnt + 1'b1;
            end
        end
    end

    // Threshold test on the freshly updated P and R: P > 0 and P^2*2^S > N*R^2
    always_comb begin
        // NOTE: every signal here is assigned on every pass, so no latch is inferred.
        p_pos   = !p_acc[PW-1] && (p_acc != '0);
        p_u     = CW'($unsigned(p_acc));
        r_u     = CW'(r_acc);
        lhs     = (p_u * p_u) << THR_SHIFT;
        rhs     = CW'(THR_NUM) * r_u * r_u;
        hit_now = s0_warm && p_pos && (lhs > rhs);
    end

    // Register the test result with the P/R/index snapshot it belongs to
    always_ff @(posedge clk) begin
        if (rst) begin
            ev_valid <= 1'b0;
            ev_hit   <= 1'b0;
            ev_p     <= '0;
            ev_r     <= '0;
            ev_idx   <= '0;
        end else begin
            // rearm discards any result still in flight so the search restarts clean
            ev_valid <= s0_valid && !rearm;
            ev_hit   <= hit_now;
            ev_p     <= p_acc;
            ev_r     <= r_acc;
            ev_idx   <= cur_idx - IDX_W'(2*L - 1);
        end
    end

    // Peak-search FSM: find threshold crossing, follow the maximum, report after PEAK_WIN quiet samples
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SEARCH;
            best_p    <= '0;
            best_r    <= '0;
            best_idx  <= '0;
            quiet     <= '0;
            det_valid <= 1'b0;
            det_index <= '0;
            det_p     <= '0;
            det_r     <= '0;
            busy      <= 1'b0;
            locked    <= 1'b0;
        end else begin
            det_valid <= 1'b0;
            if (rearm) begin
                state    <= SEARCH;
                best_p   <= '0;
                best_r   <= '0;
                best_idx <= '0;
                quiet    <= '0;
                busy     <= 1'b0;
                locked   <= 1'b0;
            end else if (ev_valid) begin
                case (state)
                    SEARCH: begin
                        if (ev_hit) begin
                            state    <= TRACK;
                            best_p   <= ev_p;
                            best_r   <= ev_r;
                            best_idx <= ev_idx;
                            quiet    <= '0;
                            busy     <= 1'b1;
                        end
                    end
                    TRACK: begin
                        // Ties do not move the peak, so a plateau reports its earliest index
                        if (ev_p > best_p) begin
                            best_p   <= ev_p;
                            best_r   <= ev_r;
                            best_idx <= ev_idx;
                            quiet    <= '0;
                        end else begin
                            quiet <= quiet + 1'b1;
                            if (quiet == QW'(PEAK_WIN - 1)) begin
                                state     <= DONE;
                                det_valid <= 1'b1;
                                det_index <= best_idx;
                                det_p     <= best_p;
                                det_r     <= best_r;
                                busy      <= 1'b0;
                                locked    <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
